// File: rtl/frame_capture_ctrl_if.sv
// rtl/frame_capture_ctrl_if.sv - host control and video-timing signals of the frame capture controller
interface frame_capture_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] n_frames;
  logic             fval;
  logic             lval;
  logic             dval;
  logic             gen_en;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;
  logic             err_width;
  logic             err_height;
  logic             err_timeout;

  modport master (
    output start, stop, n_frames, fval, lval, dval,
    input  gen_en, busy, frame_done, frame_cnt, err_width, err_height, err_timeout
  );

  modport slave (
    input  start, stop, n_frames, fval, lval, dval,
    output gen_en, busy, frame_done, frame_cnt, err_width, err_height, err_timeout
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - sequences the video timing generator and checks returned frame geometry
module frame_capture_ctrl #(
  parameter int WIDTH          = 640,
  parameter int HEIGHT         = 480,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int QUIET_CYCLES   = 16384,
  parameter int CNT_W          = 16
) (
  input logic                  clk,
  input logic                  rstb,
  frame_capture_ctrl_if.slave  bus
);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int QUIET_W = $clog2(QUIET_CYCLES + 1);
  // One spare code above the nominal size so over-long lines/frames stay distinguishable
  localparam int PIX_W   = $clog2(WIDTH + 2);
  localparam int LINE_W  = $clog2(HEIGHT + 2);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic               fval_d, lval_d;
  logic [CNT_W-1:0]   n_frames_q, frame_cnt, frame_cnt_inc;
  logic [TMO_W-1:0]   tmo;
  logic [QUIET_W-1:0] quiet;
  logic [PIX_W-1:0]   pix_cnt, pix_base, pix_nxt;
  logic [LINE_W-1:0]  line_cnt, line_eff;
  logic               stop_pend, gen_en, frame_done;
  logic               err_width, err_height, err_timeout;
  logic               fval_rise, fval_fall, lval_rise, lval_fall;
  logic               tmo_hit, quiet_hit, last_frame;
  logic               do_start, do_arm_go, do_timeout, do_stop, do_frame_end;

  assign fval_rise = bus.fval & ~fval_d;
  assign fval_fall = ~bus.fval & fval_d;
  assign lval_rise = bus.lval & ~lval_d;
  assign lval_fall = ~bus.lval & lval_d;

  assign tmo_hit       = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign quiet_hit     = (quiet == QUIET_W'(QUIET_CYCLES - 1)) & ~bus.fval;
  assign frame_cnt_inc = frame_cnt + 1'b1;
  // A stop arriving on the very cycle fval falls also ends the run
  assign last_frame    = stop_pend | bus.stop |
                         ((n_frames_q != '0) && (frame_cnt_inc == n_frames_q));

  assign pix_base = lval_rise ? '0 : pix_cnt;
  assign pix_nxt  = (bus.lval && bus.dval && pix_base != '1) ? pix_base + 1'b1 : pix_base;
  assign line_eff = (lval_fall && line_cnt != '1) ? line_cnt + 1'b1 : line_cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    do_start     = 1'b0;
    do_arm_go    = 1'b0;
    do_timeout   = 1'b0;
    do_stop      = 1'b0;
    do_frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          do_start  = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (bus.stop) begin
          do_stop   = 1'b1;
          state_nxt = DRAIN;
        end else if (fval_rise) begin
          do_arm_go = 1'b1;
          state_nxt = ACTIVE;
        end else if (tmo_hit) begin
          do_timeout = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      ACTIVE: begin
        if (fval_fall) begin
          do_frame_end = 1'b1;
          state_nxt    = last_frame ? IDLE : ARM;
        end else if (tmo_hit) begin
          do_timeout = 1'b1;
          state_nxt  = DRAIN;
        end else if (bus.stop) begin
          do_stop = 1'b1;
        end
      end
      DRAIN: begin
        if (quiet_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fval_d      <= 1'b0;
      lval_d      <= 1'b0;
      n_frames_q  <= '0;
      frame_cnt   <= '0;
      tmo         <= '0;
      quiet       <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      stop_pend   <= 1'b0;
      gen_en      <= 1'b0;
      frame_done  <= 1'b0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      fval_d     <= bus.fval;
      lval_d     <= bus.lval;
      frame_done <= do_frame_end;

      if (do_start) begin
        n_frames_q  <= bus.n_frames;
        frame_cnt   <= '0;
        err_width   <= 1'b0;
        err_height  <= 1'b0;
        err_timeout <= 1'b0;
        gen_en      <= 1'b1;
      end else if (do_stop || do_timeout || (do_frame_end && last_frame)) begin
        gen_en <= 1'b0;
      end

      if (do_timeout) err_timeout <= 1'b1;

      if (do_start || do_arm_go || do_frame_end) tmo <= '0;
      else if (state == ARM || state == ACTIVE)  tmo <= tmo + 1'b1;

      if (state == DRAIN) quiet <= bus.fval ? '0 : quiet + 1'b1;
      else                quiet <= '0;

      if (do_arm_go) line_cnt <= '0;
      else if (state == ACTIVE) line_cnt <= line_eff;

      if (state == ACTIVE) begin
        pix_cnt <= pix_nxt;
        if (lval_fall && pix_cnt != PIX_W'(WIDTH)) err_width <= 1'b1;
      end

      if (do_frame_end) begin
        frame_cnt <= frame_cnt_inc;
        if (line_eff != LINE_W'(HEIGHT)) err_height <= 1'b1;
      end

      if (do_start || do_frame_end || do_timeout) stop_pend <= 1'b0;
      else if (state == ACTIVE && do_stop)        stop_pend <= 1'b1;
    end
  end

  assign bus.gen_en      = gen_en;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_done  = frame_done;
  assign bus.frame_cnt   = frame_cnt;
  assign bus.err_width   = err_width;
  assign bus.err_height  = err_height;
  assign bus.err_timeout = err_timeout;
endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences the pseudo video timing generator: drives its `en`, runs single, N-frame or continuous capture, and stops cleanly.
- Monitors the returned fval/lval/dval stream, counting completed frames and flagging geometry mismatches and timeouts.
- Sits between the testbench/host control registers and the timing generator, in front of the median filter datapath.

Parameters:
- WIDTH, 640, expected dval-high cycles per line.
- HEIGHT, 480, expected lines per frame.
- TIMEOUT_CYCLES, 1000000, maximum cycles waiting for an fval edge in ARM or ACTIVE.
- QUIET_CYCLES, 16384, consecutive fval-low cycles needed to leave DRAIN.
- CNT_W, 16, width of the frame count and n_frames.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin capture
- stop  in  1  one-cycle pulse; abort or finish capture
- n_frames  in  CNT_W  frames to capture; 0 = continuous; sampled on accepted start
- fval  in  1  frame valid from generator
- lval  in  1  line valid from generator
- dval  in  1  data valid from generator
- gen_en  out  1  enable to generator
- busy  out  1  high when state != IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- frame_cnt  out  CNT_W  frames completed since last accepted start
- err_width  out  1  sticky; a line had dval count != WIDTH
- err_height  out  1  sticky; a frame had line count != HEIGHT
- err_timeout  out  1  sticky; TIMEOUT_CYCLES exceeded

Behaviour:
- Reset values: all outputs 0, state IDLE, all internal counters 0, fval_d/lval_d 0.
- fval_d and lval_d register the previous fval and lval. Edges are derived from them: rise = x & ~x_d, fall = ~x & x_d.
- States: IDLE, ARM, ACTIVE, DRAIN.
- IDLE:
  - start & ~stop: latch n_frames; clear frame_cnt and the three err flags; gen_en<=1; tmo<=0; go to ARM.
  - start & stop in the same cycle: stay IDLE.
  - start while busy: ignored.
- ARM:
  - tmo increments each cycle.
  - fval rise: tmo<=0, line_cnt<=0, go to ACTIVE.
  - tmo==TIMEOUT_CYCLES-1 without a rise: err_timeout<=1, gen_en<=0, go to DRAIN.
  - stop: gen_en<=0, go to DRAIN.
- ACTIVE:
  - tmo increments each cycle. Timeout: err_timeout<=1, gen_en<=0, go to DRAIN; the frame is not counted.
  - lval rise: pix_cnt<=0.
  - lval & dval: pix_cnt++ (saturating).
  - lval fall: if the final pix_cnt (including a dval on the last lval-high cycle) != WIDTH, err_width<=1; line_cnt++ (saturating).
  - stop: gen_en<=0; set stop_pend; remain in ACTIVE.
  - fval fall:
    - frame_done<=1 for one cycle; frame_cnt++ (wraps).
    - If line_cnt (including an lval fall in the same cycle) != HEIGHT, err_height<=1.
    - If stop_pend, or n_frames!=0 and frame_cnt+1==n_frames: gen_en<=0, clear stop_pend, go to IDLE.
    - Otherwise go to ARM with tmo<=0 and gen_en still 1.
- DRAIN:
  - gen_en=0. quiet counts consecutive fval-low cycles and resets to 0 on fval high.
  - quiet==QUIET_CYCLES-1 with fval low: go to IDLE.
  - No counting or checking happens in DRAIN. start and stop are ignored.
- Timing: frame_done is asserted the cycle after the clock edge at which fval is first sampled low; frame_cnt updates in the same cycle. gen_en changes the cycle after the triggering input is sampled.
- Error flags are sticky until the next accepted start. Reset mid-operation returns everything to reset values immediately.
- tmo width is $clog2(TIMEOUT_CYCLES+1); quiet width is $clog2(QUIET_CYCLES+1).

Test Plan:
- WIDTH=8, HEIGHT=4, n_frames=1, start pulse -> gen_en=1 next cycle; after fval falls, one frame_done pulse, frame_cnt=1, gen_en=0, busy=0, all err=0.
- n_frames=3 -> exactly 3 frame_done pulses, frame_cnt=3; gen_en stays high between frames; ends in IDLE.
- n_frames=0, then stop during frame 2 ACTIVE -> frame 2 completes, frame_cnt=2, gen_en drops the cycle after stop, IDLE at fval fall, no third fval.
- Stimulus with 7 dval per line and 5 lines per frame -> err_width=1, err_height=1; both clear on the next start.
- TIMEOUT_CYCLES=100 with fval held low -> err_timeout=1 at cycle 100 after ARM entry, then DRAIN, then IDLE after QUIET_CYCLES low cycles.
- start and stop in the same cycle while IDLE -> stays IDLE, gen_en=0. Reset asserted mid-frame -> all outputs 0 asynchronously.
